// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the VGA fetcher,
// the HDMI fetcher and the CPU. It issues at most one RAM access per cycle.
// Read results come back on a shared registered bus, and per-owner valid
// pulses say which requester each result belongs to. cpu_stall lets the
// clock block model ULA-style contention.
module vram_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int RD_LAT       = 1,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          clk_vram,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    output logic          vga_rvalid,
    input  logic          hdmi_req,
    input  logic [AW-1:0] hdmi_addr,
    output logic          hdmi_ack,
    output logic          hdmi_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic          cpu_stall,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int WCW = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_HDMI = 2'd2,
        OWN_CPU  = 2'd3
    } owner_t;

    owner_t          grant;
    owner_t          issue_tag;
    owner_t          rr_last;
    owner_t          tag_p [RD_LAT];
    logic            cpu_force;
    logic [WCW-1:0]  wait_cnt;
    logic [AW-1:0]   addr_hold;

    // Pick this cycle's winner: a starved CPU first, then video round-robin,
    // then the CPU. Nothing is granted while reset is held.
    always_comb begin
        grant     = OWN_NONE;
        cpu_force = cpu_req && (wait_cnt == WCW'(CPU_MAX_WAIT));
        if (reset) begin
            grant = OWN_NONE;
        end else if (cpu_force) begin
            grant = OWN_CPU;
        end else if (vga_req && hdmi_req) begin
            grant = (rr_last == OWN_HDMI) ? OWN_VGA : OWN_HDMI;
        end else if (vga_req) begin
            grant = OWN_VGA;
        end else if (hdmi_req) begin
            grant = OWN_HDMI;
        end else if (cpu_req) begin
            grant = OWN_CPU;
        end
    end

    assign vga_ack  = (grant == OWN_VGA);
    assign hdmi_ack = (grant == OWN_HDMI);
    assign cpu_ack  = (grant == OWN_CPU);

    // Route the winner to the RAM port. When nobody wins, the address stays
    // where it was, which keeps the address bus quiet.
    always_comb begin
        ram_addr  = addr_hold;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        issue_tag = grant;
        case (grant)
            OWN_VGA:  ram_addr = vga_addr;
            OWN_HDMI: ram_addr = hdmi_addr;
            OWN_CPU: begin
                ram_addr = cpu_addr;
                ram_we   = cpu_we;
                if (cpu_we) begin
                    issue_tag = OWN_NONE;
                end
            end
            default: ram_addr = addr_hold;
        endcase
    end

    // Arbitration state: round-robin pointer, CPU starvation counter, stall
    // flag and the held RAM address.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            rr_last   <= OWN_HDMI;
            wait_cnt  <= '0;
            cpu_stall <= 1'b0;
            addr_hold <= '0;
        end else begin
            addr_hold <= ram_addr;
            cpu_stall <= cpu_req & ~cpu_ack;
            if (vga_req && hdmi_req && !cpu_force) begin
                rr_last <= grant;
            end
            if (!cpu_req || cpu_ack) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WCW'(CPU_MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
        end
    end

    // Stage p0..p(RD_LAT-1): owner tags move alongside the RAM read latency.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= OWN_NONE;
            end
        end else begin
            tag_p[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Final stage: capture RAM data and pulse the valid for the owner whose
    // tag has just come out of the pipeline.
    always_ff @(posedge clk_vram) begin
        if (reset) begin
            vga_rvalid  <= 1'b0;
            hdmi_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
            rd_data     <= '0;
        end else begin
            vga_rvalid  <= (tag_p[RD_LAT-1] == OWN_VGA);
            hdmi_rvalid <= (tag_p[RD_LAT-1] == OWN_HDMI);
            cpu_rvalid  <= (tag_p[RD_LAT-1] == OWN_CPU);
            if (tag_p[RD_LAT-1] != OWN_NONE) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a write-first,
// one-cycle-latency RAM model preloaded with pattern addr[7:0] ^ 0x5A.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk_vram = 1'b0;
    logic          reset;
    logic          vga_req, hdmi_req, cpu_req, cpu_we;
    logic [AW-1:0] vga_addr, hdmi_addr, cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          vga_ack, vga_rvalid, hdmi_ack, hdmi_rvalid;
    logic          cpu_ack, cpu_rvalid, cpu_stall;
    logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;

    int tests = 0;
    int fails = 0;

    bit [DW-1:0] mem     [8192];
    bit          written [8192];

    always #5 clk_vram = ~clk_vram;

    vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .CPU_MAX_WAIT(4)) dut (
        .clk_vram   (clk_vram),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_ack    (vga_ack),
        .vga_rvalid (vga_rvalid),
        .hdmi_req   (hdmi_req),
        .hdmi_addr  (hdmi_addr),
        .hdmi_ack   (hdmi_ack),
        .hdmi_rvalid(hdmi_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .rd_data    (rd_data),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Write-first single-port RAM with one cycle of read latency.
    always @(posedge clk_vram) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
            ram_rdata         <= ram_wdata;
        end else begin
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] va,
                         input logic h, input logic [AW-1:0] ha,
                         input logic c, input logic we,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        vga_req   = v;
        vga_addr  = va;
        hdmi_req  = h;
        hdmi_addr = ha;
        cpu_req   = c;
        cpu_we    = we;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    task automatic nxt();
        @(posedge clk_vram);
        #1;
    endtask

    initial begin
        logic [7:0] t1 [4];
        t1 = '{8'h5A, 8'h5B, 8'h58, 8'h59};

        reset = 1'b1;
        drive(0, '0, 0, '0, 0, 0, '0, '0);
        repeat (2) nxt();
        @(negedge clk_vram);
        chk("rst_vga_ack",    vga_ack,    0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_cpu_stall",  cpu_stall,  0);
        chk("rst_rd_data",    rd_data,    0);
        chk("rst_ram_addr",   ram_addr,   0);
        chk("rst_ram_we",     ram_we,     0);
        nxt();
        reset = 1'b0;

        // Test 1: VGA alone, four consecutive reads.
        for (int k = 0; k < 6; k++) begin
            drive(k < 4, AW'(k), 0, '0, 0, 0, '0, '0);
            @(negedge clk_vram);
            chk("t1_vga_ack", vga_ack, (k < 4));
            if (k < 4) chk("t1_ram_addr", ram_addr, k);
            chk("t1_vga_rvalid", vga_rvalid, (k >= 2));
            if (k >= 2) chk("t1_rd_data", rd_data, t1[k-2]);
            nxt();
        end

        // Test 2: VGA and HDMI both requesting alternate, VGA first.
        for (int k = 0; k < 8; k++) begin
            drive(k < 6, 13'h0010, k < 6, 13'h0020, 0, 0, '0, '0);
            @(negedge clk_vram);
            chk("t2_vga_ack",  vga_ack,  (k < 6) && (k % 2 == 0));
            chk("t2_hdmi_ack", hdmi_ack, (k < 6) && (k % 2 == 1));
            chk("t2_vga_rvalid",  vga_rvalid,  (k >= 2) && (k % 2 == 0));
            chk("t2_hdmi_rvalid", hdmi_rvalid, (k >= 2) && (k % 2 == 1));
            if (k >= 2) chk("t2_rd_data", rd_data, (k % 2 == 0) ? 8'h4A : 8'h7A);
            nxt();
        end

        // Test 3: video saturating, CPU write forced through after 4 refusals.
        for (int k = 0; k < 6; k++) begin
            drive(k <= 4, 13'h0030, k <= 4, 13'h0040, k <= 4, 1, 13'h1800, 8'hA5);
            @(negedge clk_vram);
            chk("t3_cpu_ack",   cpu_ack,   (k == 4));
            chk("t3_cpu_stall", cpu_stall, (k >= 1) && (k <= 4));
            chk("t3_vga_ack",   vga_ack,   (k < 4) && (k % 2 == 0));
            if (k == 4) begin
                chk("t3_ram_we",    ram_we,    1);
                chk("t3_ram_addr",  ram_addr,  32'h1800);
                chk("t3_ram_wdata", ram_wdata, 8'hA5);
            end
            nxt();
        end
        chk("t3_ram_content", mem[13'h1800], 8'hA5);
        repeat (2) nxt();

        // Test 4: CPU write then read-back of the same address.
        drive(0, '0, 0, '0, 1, 1, 13'h0100, 8'h3C);
        @(negedge clk_vram);
        chk("t4_wr_ack", cpu_ack, 1);
        chk("t4_wr_we",  ram_we,  1);
        chk("t4_wr_addr", ram_addr, 32'h0100);
        nxt();
        drive(0, '0, 0, '0, 1, 0, 13'h0100, 8'h00);
        @(negedge clk_vram);
        chk("t4_rd_ack",   cpu_ack,   1);
        chk("t4_rd_we",    ram_we,    0);
        chk("t4_rd_stall", cpu_stall, 0);
        nxt();
        drive(0, '0, 0, '0, 0, 0, '0, '0);
        @(negedge clk_vram);
        chk("t4_rvalid_early", cpu_rvalid, 0);
        nxt();
        @(negedge clk_vram);
        chk("t4_rvalid",  cpu_rvalid, 1);
        chk("t4_rd_data", rd_data,    8'h3C);
        nxt();
        @(negedge clk_vram);
        chk("t4_rvalid_after", cpu_rvalid, 0);
        nxt();

        // Test 5: reset one cycle after a VGA ack discards the read.
        drive(1, 13'h0005, 0, '0, 0, 0, '0, '0);
        @(negedge clk_vram);
        chk("t5_vga_ack", vga_ack, 1);
        nxt();
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, 0, '0, '0);
        @(negedge clk_vram);
        chk("t5_ack_in_reset", vga_ack, 0);
        nxt();
        reset = 1'b0;
        @(negedge clk_vram);
        chk("t5_vga_rvalid", vga_rvalid, 0);
        chk("t5_rd_data",    rd_data,    0);
        chk("t5_ram_addr",   ram_addr,   0);
        chk("t5_ram_we",     ram_we,     0);
        chk("t5_cpu_stall",  cpu_stall,  0);
        nxt();
        @(negedge clk_vram);
        chk("t5_vga_rvalid_late", vga_rvalid, 0);
        nxt();

        // Test 6: CPU request dropped before ack; the re-raised request waits
        // the full 4 cycles again.
        for (int k = 0; k < 11; k++) begin
            drive(k <= 8, 13'h0050, k <= 8, 13'h0060,
                  (k <= 2) || (k >= 4 && k <= 8), 0, 13'h0200, 8'h00);
            @(negedge clk_vram);
            chk("t6_cpu_ack",   cpu_ack,   (k == 8));
            chk("t6_cpu_stall", cpu_stall, (k >= 1 && k <= 3) || (k >= 5 && k <= 8));
            chk("t6_cpu_rvalid", cpu_rvalid, (k == 10));
            if (k == 10) chk("t6_rd_data", rd_data, 8'h5A);
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
